// File: rtl/feature_map_collector_if.sv
// Feature-row bus from the conv layer plus the single-word drain stream.
// master = conv layer / downstream consumer side, slave = feature_map_collector.
//
// Handshake: the row side is strobe-only (one valid cycle per row, no ready).
// The stream side is strict valid/ready: a word transfers on a rising edge where
// out_valid && out_ready are both high; out_valid and the word fields stay
// stable until that transfer, and out_valid never depends on out_ready.
interface feature_map_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WORDS  = 6,
  parameter int IDX_W      = 2,
  parameter int ROW_W      = 3
) ();
  logic                            valid;
  logic [IDX_W-1:0]                feature_idx;
  logic [ROW_W-1:0]                feature_row;
  logic [ROW_WORDS*DATA_WIDTH-1:0] data_in;

  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [IDX_W-1:0]                out_feature;
  logic [ROW_W-1:0]                out_row;
  logic [2:0]                      out_col;
  logic                            out_last;

  modport master (
    output valid, feature_idx, feature_row, data_in, out_ready,
    input  out_valid, out_data, out_feature, out_row, out_col, out_last
  );

  modport slave (
    input  valid, feature_idx, feature_row, data_in, out_ready,
    output out_valid, out_data, out_feature, out_row, out_col, out_last
  );
endinterface

// File: rtl/feature_map_collector.sv
// feature_map_collector: captures a full frame of conv feature rows into a
// register buffer, then drains it word by word over a valid/ready stream.
// Optional macro FMC_RELU_EN: zero any negative word (sign bit set) at capture.
module feature_map_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WORDS  = 6,
  parameter int ROWS       = 6,
  parameter int FEATURES   = 4,
  parameter int IDX_W      = 2,
  parameter int ROW_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  feature_map_collector_if.slave bus,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overflow,
  output logic                  row_err,
  output logic                  dbg_state
);

  localparam int MASK_W = FEATURES * ROWS;
  localparam int ROW_BITS = ROW_WORDS * DATA_WIDTH;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state;
  logic [MASK_W-1:0]   mask;
  logic [MASK_W-1:0]   mask_hot;
  logic [IDX_W-1:0]    f_ptr;
  logic [ROW_W-1:0]    r_ptr;
  logic [2:0]          c_ptr;
  logic                in_range;
  logic                last_ptr;
  logic [ROW_BITS-1:0] cap_row;
  logic [ROW_BITS-1:0] sel_row;
  logic [DATA_WIDTH-1:0] sel_words [ROW_WORDS];

  // Row storage; contents are don't-care after reset, so no reset term.
  logic [ROW_BITS-1:0] row_buf [FEATURES][ROWS];

  assign in_range = (int'(bus.feature_idx) < FEATURES) && (int'(bus.feature_row) < ROWS);
  assign last_ptr = (int'(f_ptr) == FEATURES - 1) && (int'(r_ptr) == ROWS - 1) &&
                    (int'(c_ptr) == ROW_WORDS - 1);

  // One-hot mask bit for the incoming row (idx*ROWS + row); empty when out of range.
  always_comb begin
    mask_hot = '0;
    for (int i = 0; i < MASK_W; i++) begin
      mask_hot[i] = in_range &&
                    (i == int'(bus.feature_idx) * ROWS + int'(bus.feature_row));
    end
  end

  // Capture path: word 0 sits in the most-significant slice; optional ReLU per word.
  for (genvar g = 0; g < ROW_WORDS; g++) begin : g_word
    logic [DATA_WIDTH-1:0] w_in;
    assign w_in = bus.data_in[(ROW_WORDS-1-g)*DATA_WIDTH +: DATA_WIDTH];
`ifdef FMC_RELU_EN
    assign cap_row[(ROW_WORDS-1-g)*DATA_WIDTH +: DATA_WIDTH] =
      w_in[DATA_WIDTH-1] ? '0 : w_in;
`else
    assign cap_row[(ROW_WORDS-1-g)*DATA_WIDTH +: DATA_WIDTH] = w_in;
`endif
    assign sel_words[g] = sel_row[(ROW_WORDS-1-g)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Buffer write: only in-range rows during FILL; rewrites simply overwrite.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.valid && in_range) begin
      row_buf[bus.feature_idx][bus.feature_row] <= cap_row;
    end
  end

  // Stream side is a pure read of the buffer at the drain pointers.
  assign sel_row         = row_buf[f_ptr][r_ptr];
  assign bus.out_valid   = busy;
  assign bus.out_data    = busy ? sel_words[c_ptr] : '0;
  assign bus.out_feature = f_ptr;
  assign bus.out_row     = r_ptr;
  assign bus.out_col     = c_ptr;
  assign bus.out_last    = busy && last_ptr;
  assign dbg_state       = (state == DRAIN);

  // Control FSM: mask tracking in FILL, pointer walk in DRAIN, sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      mask       <= '0;
      f_ptr      <= '0;
      r_ptr      <= '0;
      c_ptr      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      row_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (bus.valid) begin
            if (!in_range) begin
              row_err <= 1'b1;
            end else begin
              if ((mask & mask_hot) != '0) row_err <= 1'b1;
              mask <= mask | mask_hot;
              // The write of this cycle completes the frame: DRAIN next cycle.
              if ((mask | mask_hot) == '1) begin
                state      <= DRAIN;
                busy       <= 1'b1;
                frame_done <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          // No room to buffer rows while draining; flag and drop.
          if (bus.valid) overflow <= 1'b1;
          if (bus.out_ready) begin
            if (last_ptr) begin
              state <= FILL;
              busy  <= 1'b0;
              mask  <= '0;
              f_ptr <= '0;
              r_ptr <= '0;
              c_ptr <= '0;
            end else if (int'(c_ptr) == ROW_WORDS - 1) begin
              c_ptr <= '0;
              if (int'(r_ptr) == ROWS - 1) begin
                r_ptr <= '0;
                f_ptr <= f_ptr + IDX_W'(1);
              end else begin
                r_ptr <= r_ptr + ROW_W'(1);
              end
            end else begin
              c_ptr <= c_ptr + 3'd1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_map_collector.sv
// Directed bench for feature_map_collector: frame capture, ordered drain,
// backpressure, error/overflow flags, mid-drain reset and optional ReLU.
module tb_feature_map_collector;

  localparam int DW = 32;
  localparam int NW = 6;
  localparam int NR = 6;
  localparam int NF = 4;
  localparam int EW = 1 + 2 + 3 + 3 + DW;

  logic clk;
  logic rst_n;
  logic frame_done, busy, overflow, row_err, dbg_state;

  feature_map_collector_if #(.DATA_WIDTH(DW), .ROW_WORDS(NW), .IDX_W(2), .ROW_W(3)) bus ();

  feature_map_collector #(
    .DATA_WIDTH(DW), .ROW_WORDS(NW), .ROWS(NR), .FEATURES(NF), .IDX_W(2), .ROW_W(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .frame_done (frame_done),
    .busy       (busy),
    .overflow   (overflow),
    .row_err    (row_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_mem [NF][NR][NW];
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] stored(input logic [DW-1:0] w);
`ifdef FMC_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [NW*DW-1:0] make_row(input int idx, input int row, input int salt);
    logic [NW*DW-1:0] d;
    for (int c = 0; c < NW; c++) begin
      d[(NW-1-c)*DW +: DW] = DW'((salt << 24) | (idx << 8) | (row << 4) | c);
    end
    return d;
  endfunction

  // Expected drain order: feature, row, col; last flag on the final word.
  task automatic build_exp();
    logic lst;
    exp_q.delete();
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NW; c++) begin
          lst = (f == NF-1) && (r == NR-1) && (c == NW-1);
          exp_q.push_back({lst, f[1:0], r[2:0], c[2:0], exp_mem[f][r][c]});
        end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; leaves at posedge+1 of the following cycle.
  task automatic send_row(input int idx, input int row, input logic [NW*DW-1:0] d);
    bus.valid       = 1'b1;
    bus.feature_idx = idx[1:0];
    bus.feature_row = row[2:0];
    bus.data_in     = d;
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic record_row(input int idx, input int row, input logic [NW*DW-1:0] d);
    for (int c = 0; c < NW; c++) exp_mem[idx][row][c] = stored(d[(NW-1-c)*DW +: DW]);
  endtask

  task automatic put_row(input int idx, input int row, input int salt);
    logic [NW*DW-1:0] d;
    d = make_row(idx, row, salt);
    record_row(idx, row, d);
    send_row(idx, row, d);
  endtask

  task automatic put_frame(input int salt);
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < NR; r++) put_row(f, r, salt);
  endtask

  task automatic expect_frame_done(input string tag);
    @(negedge clk);
    check({tag, "_done"}, frame_done, 1);
    check({tag, "_busy"}, busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_pulse"}, frame_done, 0);
    @(posedge clk); #1;
  endtask

  // mode 0: ready always high; mode 1: ready toggles starting high.
  task automatic drain(input int mode, input int stop_after, input int ovf_at, output int cycles);
    int it;
    int got;
    logic [EW-1:0] a;
    logic [EW-1:0] e;
    it = 0;
    got = 0;
    build_exp();
    while (exp_q.size() > 0 && it < 2000 && got < stop_after) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((it % 2) == 0);
      bus.valid     = (it == ovf_at);
      bus.feature_idx = 2'd0;
      bus.feature_row = 3'd0;
      bus.data_in   = '1;
      @(negedge clk);
      a = {bus.out_last, bus.out_feature, bus.out_row, bus.out_col, bus.out_data};
      if (!bus.out_valid) begin
        check("drain_valid", bus.out_valid, 1);
      end else if (bus.out_ready) begin
        e = exp_q.pop_front();
        check("word", a, e);
        got++;
      end else begin
        check("hold", a, exp_q[0]);
      end
      it++;
      @(posedge clk); #1;
    end
    bus.valid = 1'b0;
    bus.out_ready = 1'b0;
    cycles = it;
    if (got < stop_after) check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    logic [NW*DW-1:0] d;
    rst_n = 1'b0;
    bus.valid = 1'b0;
    bus.feature_idx = '0;
    bus.feature_row = '0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_flags", {frame_done, busy, overflow, row_err, dbg_state}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // In-order frame, ready held high.
    put_frame(1);
    expect_frame_done("inorder");
    drain(0, 1000, -1, cyc);
    check("inorder_cycles", cyc, 144);
    @(negedge clk);
    check("inorder_busy_end", busy, 0);
    check("inorder_flags", {overflow, row_err}, 0);
    @(posedge clk); #1;

    // Backpressure: ready toggles every cycle.
    put_frame(2);
    expect_frame_done("bp");
    drain(1, 1000, -1, cyc);
    check("bp_cycles", cyc, 287);

    // Reverse order, rewrite of (1,2), then an out-of-range row.
    for (int f = NF-1; f >= 0; f--)
      for (int r = NR-1; r >= 0; r--)
        if (!(f == 0 && r == 0)) put_row(f, r, 3);
    @(negedge clk);
    check("rev_no_err_yet", row_err, 0);
    check("rev_not_full", busy, 0);
    @(posedge clk); #1;
    put_row(1, 2, 8'hA5);
    @(negedge clk);
    check("rewrite_err", row_err, 1);
    @(posedge clk); #1;
    send_row(0, 6, make_row(0, 6, 8'hEE));
    put_row(0, 0, 3);
    expect_frame_done("rev");
    check("rev_row_err", row_err, 1);
    drain(0, 1000, -1, cyc);

    // Overflow: valid on the 3rd drain cycle is dropped.
    put_frame(4);
    expect_frame_done("ovf");
    check("ovf_before", overflow, 0);
    drain(0, 1000, 2, cyc);
    @(negedge clk);
    check("ovf_flag", overflow, 1);
    @(posedge clk); #1;
    put_frame(5);
    expect_frame_done("post_ovf");
    drain(0, 1000, -1, cyc);

    // ReLU words (also covers -0.0).
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < NR; r++) begin
        d = make_row(f, r, 6);
        if (f == 2 && r == 3) begin
          d[(NW-1)*DW +: DW] = 32'hBF80_0000;
          d[(NW-2)*DW +: DW] = 32'h3F80_0000;
          d[(NW-3)*DW +: DW] = 32'h8000_0000;
        end
        record_row(f, r, d);
        send_row(f, r, d);
      end
    expect_frame_done("relu");
`ifdef FMC_RELU_EN
    check("relu_neg_model", exp_mem[2][3][0], 32'h0000_0000);
`else
    check("relu_neg_model", exp_mem[2][3][0], 32'hBF80_0000);
`endif
    drain(0, 1000, -1, cyc);

    // Reset mid-drain after 50 accepted words.
    put_frame(7);
    expect_frame_done("mid");
    drain(0, 50, -1, cyc);
    check("mid_words", cyc, 50);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_pos", {bus.out_last, bus.out_feature, bus.out_row, bus.out_col}, 0);
    check("mid_rst_flags", {frame_done, busy, overflow, row_err, dbg_state}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < NR; r++)
        if (!(f == NF-1 && r == NR-1)) put_row(f, r, 8);
    @(negedge clk);
    check("mid_mask_empty", {busy, dbg_state}, 0);
    @(posedge clk); #1;
    put_row(NF-1, NR-1, 8);
    expect_frame_done("after_rst");
    drain(0, 1000, -1, cyc);
    check("after_rst_cycles", cyc, 144);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule
